fpu_add_result_buffer: RTL and testbench

FPU_ADD_RESULT_BUFFER -- requirements
Module: fpu_add_result_buffer

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_flag_accum.sv | 38 +++
 rtl/fpu_add_result_buffer.sv | 109 ++++++++++
 tb/tb_fpu_add_result_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types: FP32 width and the result-buffer entry layout.
package fpu_pkg;

    localparam int FP32_W    = 32;
    // Widest destination tag an entry can carry; narrower tags are zero-extended.
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic [FP32_W-1:0]    result;
        logic                 overflow;
        logic                 underflow;
        logic [TAG_W_MAX-1:0] tag;
    } fpu_entry_t;

endpackage

// File: rtl/fpu_flag_accum.sv
// Sticky accrued exception flags for the adder result buffer.
module fpu_flag_accum (
    input  logic clk,
    input  logic n_rst,
    input  logic push,
    input  logic push_overflow,
    input  logic push_underflow,
    input  logic flags_clr,
    output logic acc_overflow,
    output logic acc_underflow
);

    logic acc_ovf_q, acc_ovf_d;
    logic acc_unf_q, acc_unf_d;

    // Clear first, then OR in the pushed flags so a same-cycle push wins over clear.
    always_comb begin
        acc_ovf_d = flags_clr ? 1'b0 : acc_ovf_q;
        acc_unf_d = flags_clr ? 1'b0 : acc_unf_q;
        acc_ovf_d = acc_ovf_d | (push & push_overflow);
        acc_unf_d = acc_unf_d | (push & push_underflow);
    end

    // Flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            acc_ovf_q <= 1'b0;
            acc_unf_q <= 1'b0;
        end else begin
            acc_ovf_q <= acc_ovf_d;
            acc_unf_q <= acc_unf_d;
        end
    end

    assign acc_overflow  = acc_ovf_q;
    assign acc_underflow = acc_unf_q;

endmodule

// File: rtl/fpu_add_result_buffer.sv
// FIFO buffering FP adder results with their flags and destination tag,
// plus sticky accrued overflow/underflow flags.
module fpu_add_result_buffer
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FP32_W-1:0]          result,
    input  logic                       overflow,
    input  logic                       underflow,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FP32_W-1:0]          out_result,
    output logic                       out_overflow,
    output logic                       out_underflow,
    output logic [TAG_W-1:0]           out_tag,
    input  logic                       flags_clr,
    output logic                       acc_overflow,
    output logic                       acc_underflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    fpu_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    fpu_entry_t    wr_entry;

    // Handshakes, next pointers/count and masked head outputs.
    always_comb begin
        in_ready  = (count_q < DEPTH_CNT);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;

        wr_entry           = '0;
        wr_entry.result    = result;
        wr_entry.overflow  = overflow;
        wr_entry.underflow = underflow;
        wr_entry.tag       = TAG_W_MAX'(in_tag);

        // Power-of-two depth: pointer arithmetic wraps naturally.
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        out_result    = '0;
        out_overflow  = 1'b0;
        out_underflow = 1'b0;
        out_tag       = '0;
        if (out_valid) begin
            out_result    = mem_q[rd_ptr_q].result;
            out_overflow  = mem_q[rd_ptr_q].overflow;
            out_underflow = mem_q[rd_ptr_q].underflow;
            out_tag       = mem_q[rd_ptr_q].tag[TAG_W-1:0];
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; unreset since outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    fpu_flag_accum u_flag_accum (
        .clk            (clk),
        .n_rst          (n_rst),
        .push           (push),
        .push_overflow  (overflow),
        .push_underflow (underflow),
        .flags_clr      (flags_clr),
        .acc_overflow   (acc_overflow),
        .acc_underflow  (acc_underflow)
    );

    assign count = count_q;

endmodule

// File: tb/tb_fpu_add_result_buffer.sv
// Directed self-checking bench for fpu_add_result_buffer (DEPTH=4, TAG_W=5).
module tb_fpu_add_result_buffer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic [4:0]  out_tag;
    logic        flags_clr;
    logic        acc_overflow;
    logic        acc_underflow;
    logic [2:0]  count;

    int n_assert = 0;
    int n_fail   = 0;

    fpu_add_result_buffer #(.DEPTH(4), .TAG_W(5)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .result        (result),
        .overflow      (overflow),
        .underflow     (underflow),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_tag       (out_tag),
        .flags_clr     (flags_clr),
        .acc_overflow  (acc_overflow),
        .acc_underflow (acc_underflow),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_push(input logic v, input logic [31:0] r, input logic [4:0] t,
                            input logic o, input logic u);
        in_valid  = v;
        result    = r;
        in_tag    = t;
        overflow  = o;
        underflow = u;
    endtask

    logic [31:0] fill [4];
    logic [31:0] stream [10];

    initial begin
        fill[0] = 32'h43173333;
        fill[1] = 32'h411B3333;
        fill[2] = 32'hC11B3333;
        fill[3] = 32'hC4392CCD;
        for (int i = 0; i < 10; i++) stream[i] = 32'h3F800000 + 32'(i);

        n_rst = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
        set_push(1'b0, '0, '0, 1'b0, 1'b0);
        tick(); tick();
        n_rst = 1'b1;
        #1;

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_acc", 64'({acc_overflow, acc_underflow}), 64'd0);

        // Single push, latency of one cycle
        set_push(1'b1, 32'h433EB333, 5'd3, 1'b0, 1'b0);
        #1;
        chk("lat_out_valid_before", 64'(out_valid), 64'd0);
        tick();
        set_push(1'b0, '0, '0, 1'b0, 1'b0);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_out_result", 64'(out_result), 64'h433EB333);
        chk("lat_out_tag", 64'(out_tag), 64'd3);
        chk("lat_count", 64'(count), 64'd1);

        // Pop it, then pop while empty
        out_ready = 1'b1;
        tick();
        chk("pop_count", 64'(count), 64'd0);
        chk("pop_out_result_mask", 64'(out_result), 64'd0);
        tick();
        out_ready = 1'b0;
        chk("empty_pop_count", 64'(count), 64'd0);
        chk("empty_out_valid", 64'(out_valid), 64'd0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            set_push(1'b1, fill[i], 5'(i + 1), 1'b0, 1'b0);
            tick();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        // Fifth push must be rejected
        set_push(1'b1, 32'h40000000, 5'd7, 1'b0, 1'b0);
        tick();
        chk("full_reject_count", 64'(count), 64'd4);
        chk("full_head_stable", 64'(out_result), 64'(fill[0]));
        chk("full_head_tag", 64'(out_tag), 64'd1);

        // Pop at full with push held: pop only, push completes next cycle
        set_push(1'b1, 32'h3F800000, 5'd5, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("full_pop_count", 64'(count), 64'd3);
        chk("full_pop_in_ready", 64'(in_ready), 64'd1);
        tick();
        set_push(1'b0, '0, '0, 1'b0, 1'b0);
        chk("full_refill_count", 64'(count), 64'd4);

        // Drain in order
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("drain_%0d", i), 64'(out_result), 64'(fill[i]));
            chk($sformatf("drain_tag_%0d", i), 64'(out_tag), 64'(i + 1));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("drain_last", 64'(out_result), 64'h3F800000);
        chk("drain_last_tag", 64'(out_tag), 64'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_empty_count", 64'(count), 64'd0);
        chk("drain_empty_valid", 64'(out_valid), 64'd0);

        // Streaming push+pop at count=2 with pointer wrap
        for (int i = 0; i < 2; i++) begin
            set_push(1'b1, stream[i], 5'(i), 1'b0, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_push(1'b1, stream[k + 2], 5'(k + 2), 1'b0, 1'b0);
            #1;
            chk($sformatf("stream_data_%0d", k), 64'(out_result), 64'(stream[k]));
            chk($sformatf("stream_tag_%0d", k), 64'(out_tag), 64'(k));
            tick();
            chk($sformatf("stream_count_%0d", k), 64'(count), 64'd2);
        end
        set_push(1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 8; k < 10; k++) begin
            #1;
            chk($sformatf("stream_tail_%0d", k), 64'(out_result), 64'(stream[k]));
            tick();
        end
        out_ready = 1'b0;
        chk("stream_end_count", 64'(count), 64'd0);

        // Accrued flags
        set_push(1'b1, 32'h7F800000, 5'd9, 1'b1, 1'b0);
        tick();
        set_push(1'b0, '0, '0, 1'b0, 1'b0);
        chk("acc_ovf_set", 64'(acc_overflow), 64'd1);
        chk("acc_unf_clear", 64'(acc_underflow), 64'd0);
        chk("head_ovf_flag", 64'(out_overflow), 64'd1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("acc_ovf_cleared", 64'(acc_overflow), 64'd0);
        flags_clr = 1'b1;
        set_push(1'b1, 32'h00000001, 5'd10, 1'b0, 1'b1);
        tick();
        flags_clr = 1'b0;
        set_push(1'b0, '0, '0, 1'b0, 1'b0);
        chk("acc_unf_push_wins", 64'(acc_underflow), 64'd1);
        chk("acc_ovf_after_clr", 64'(acc_overflow), 64'd0);
        chk("acc_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("head_unf_flag", 64'(out_underflow), 64'd1);
        chk("acc_unf_after_pop", 64'(acc_underflow), 64'd1);

        // Reset mid-operation with 3 entries
        for (int i = 0; i < 2; i++) begin
            set_push(1'b1, fill[i], 5'(i + 20), 1'b1, 1'b0);
            tick();
        end
        set_push(1'b0, '0, '0, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd3);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_outputs", 64'({out_result, out_overflow, out_underflow, out_tag}), 64'd0);
        chk("mid_rst_acc", 64'({acc_overflow, acc_underflow}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
